bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
Sequences every external bus cycle for the CPU core and arbitrates the external bus between the core and an external DMA master. It turns a level request from the microcode sequencer into a timed setup/strobe/hold cycle on addr/data/rd/wr/mem_io, and stretches the strobe while WAIT is asserted. It grants the bus to DMA only at cycle boundaries. It sits between cpu_top's microcode/MAR/MDR logic and the chip pins.

Parameters:
ADDR_W, 22, external address width
DATA_W, 8, external data width
SETUP_CYC, 1, cycles addr/mem_io are stable before the strobe (>=1)
STROBE_CYC, 2, minimum rd/wr assertion cycles (>=1)
HOLD_CYC, 1, cycles addr/data are held after the strobe (>=1)
TIMEOUT_CYC, 255, strobe cycles before a bus error is raised (only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock; all logic on rising edge
arst  in  1  reset; synchronous, active-high
cpu_req  in  1  level request for a bus cycle
cpu_we  in  1  1 = write, 0 = read
cpu_mem_io  in  1  1 = memory space, 0 = I/O space
cpu_addr  in  ADDR_W  cycle address (MAR)
cpu_wdata  in  DATA_W  write data (MDR)
cpu_rdata  out  DATA_W  captured read data
cpu_done  out  1  one-cycle completion pulse
busy  out  1  state != IDLE
dma_req  in  1  external DMA bus request
dma_ack  out  1  bus granted to DMA
WAIT  in  1  wait-state request from slow device
data_in  in  DATA_W  external data bus in
addr  out  ADDR_W  external address
data_out  out  DATA_W  external write data
data_oe  out  1  data_out drive enable (pad tri-state control)
rd  out  1  read strobe
wr  out  1  write strobe
mem_io  out  1  space select
bus_err  out  1  timeout flag (tied 0 without BUS_TIMEOUT_EN)

Behaviour:
- Reset: state is IDLE. addr, data_out, and cpu_rdata are 0. data_oe, rd, wr, mem_io, dma_ack, cpu_done, busy, and bus_err are 0. Reset applied mid-cycle or mid-grant aborts it at the next edge, with no cpu_done pulse.
- States: IDLE, SETUP, STROBE, HOLD, DMA.
- IDLE, with dma_req=1: go to DMA. DMA has priority over cpu_req.
- IDLE, else with cpu_req=1 and cpu_done=0: latch cpu_addr, cpu_we, cpu_mem_io, and cpu_wdata; go to SETUP. A request seen while cpu_done=1 is ignored for that cycle.
- SETUP: addr and mem_io are driven from the latched values. data_oe=cpu_we, data_out=wdata. rd=wr=0. Stay SETUP_CYC cycles, then go to STROBE.
- STROBE: rd=~we and wr=we. A counter runs from STROBE_CYC. Leave STROBE on the edge where the counter has expired and WAIT=0; WAIT is sampled every edge, so WAIT=1 adds whole cycles. On that edge, a read captures data_in into cpu_rdata. Then go to HOLD.
- HOLD: rd=wr=0. addr, mem_io, data_oe, and data_out are held. After HOLD_CYC cycles, go to IDLE and set cpu_done=1 for exactly one cycle.
- Zero-wait read latency is SETUP_CYC+STROBE_CYC+HOLD_CYC edges from acceptance to cpu_done (4 with defaults).
- dma_req rising mid-cycle never truncates a CPU cycle. The grant is taken from IDLE only, after cpu_done.
- DMA state: dma_ack=1; data_oe=rd=wr=0. addr and mem_io are held at their last values. On dma_req=0, dma_ack drops on the next edge and the state returns to IDLE. A pending cpu_req is then served.
- Counters saturate and never wrap. Parameters below 1 are illegal; the implementation adds an elaboration-time check.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: a strobe counter counts STROBE cycles. When it reaches TIMEOUT_CYC with WAIT still 1, the controller forces the exit to HOLD, sets cpu_rdata=8'hFF, and sets bus_err=1 together with cpu_done. bus_err is sticky until reset or the next accepted request.
- Undefined: WAIT may stretch the strobe indefinitely, and bus_err is constant 0.

Decomposition:
- Package bus_ctrl_pkg holds the state enum typedef (bus_state_t) and the default timing constants (SETUP/STROBE/HOLD/TIMEOUT).
- One sub-module, bus_phase_timer: a loadable down-counter with an expired flag, reused for the setup, strobe, and hold phases.

Test Plan:
- Read, WAIT=0, addr=22'h12345, data_in=8'hA5 → rd high for 2 cycles, cpu_rdata=8'hA5, cpu_done 4 edges after accept, wr=0 throughout.
- Write 8'h3C to I/O 22'h00080 → mem_io=0, data_oe=1 from SETUP through HOLD, wr high for 2 cycles, data_out=8'h3C.
- Read with WAIT high for 3 strobe cycles → rd high for 5 cycles, done at 7 edges, data captured on the last strobe edge only.
- dma_req asserted during STROBE → CPU cycle completes, cpu_done pulses, dma_ack rises the next edge. dma_req drops → dma_ack falls the next edge, then a queued cpu_req starts.
- arst pulse during STROBE → all outputs 0 at the next edge, no cpu_done.
- (BUS_TIMEOUT_EN, TIMEOUT_CYC=8) WAIT stuck high → bus_err=1 with cpu_done and cpu_rdata=8'hFF. The next request clears bus_err.

Source files
------------

// File: rtl/bus_cycle_ctrl_pkg.sv
// bus_ctrl_pkg: shared types and default timing for bus_cycle_ctrl.
//   bus_state_t     : controller state encoding (also exported on state_o)
//   DEF_*_CYC       : default setup/strobe/hold/timeout cycle counts
//   CNT_W           : width of the phase and timeout counters
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DMA    = 3'd4
  } bus_state_t;

  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_STROBE_CYC  = 2;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_TIMEOUT_CYC = 255;

  localparam int CNT_W = 16;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// bus_cycle_ctrl_if: groups the CPU-side request signals, the DMA handshake
// and the external pin signals of bus_cycle_ctrl.
//   modport master : the controller (drives pins, strobes, done, dma_ack)
//   modport slave  : the environment (core, DMA master and pins)
// Handshake rules:
//   cpu_req is a level; a cycle is accepted on an edge where the controller is
//   idle, dma_req=0 and cpu_done=0. cpu_done pulses one cycle when the cycle
//   ends. dma_req is a level; dma_ack is high for as long as the bus is
//   granted and drops one edge after dma_req falls.
interface bus_cycle_ctrl_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_mem_io;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              busy;
  logic              dma_req;
  logic              dma_ack;
  logic              WAIT;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              rd;
  logic              wr;
  logic              mem_io;
  logic              bus_err;

  modport master (
    input  cpu_req, cpu_we, cpu_mem_io, cpu_addr, cpu_wdata,
    input  dma_req, WAIT, data_in,
    output cpu_rdata, cpu_done, busy, dma_ack,
    output addr, data_out, data_oe, rd, wr, mem_io, bus_err
  );

  modport slave (
    output cpu_req, cpu_we, cpu_mem_io, cpu_addr, cpu_wdata,
    output dma_req, WAIT, data_in,
    input  cpu_rdata, cpu_done, busy, dma_ack,
    input  addr, data_out, data_oe, rd, wr, mem_io, bus_err
  );
endinterface

// File: rtl/bus_cycle_ctrl_timer.sv
// bus_phase_timer: loadable saturating down-counter shared by the setup,
// strobe and hold phases.
//   clk, arst   : clock, synchronous active-high reset
//   load_i      : load load_val_i (phase length minus one)
//   load_val_i  : value to load
//   expired_o   : counter is zero, i.e. the current cycle is the phase's last
module bus_phase_timer
  import bus_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences external bus cycles (setup/strobe/hold) for the
// CPU core and grants the bus to an external DMA master between cycles.
//   clk, arst : clock, synchronous active-high reset
//   bus       : bus_cycle_ctrl_if.master (CPU request, DMA handshake, pins)
//   state_o   : current controller state, for observation
// Optional feature macro BUS_TIMEOUT_EN: when defined, a strobe held by WAIT
// for TIMEOUT_CYC cycles is forced to end, returns all-ones read data and
// raises a sticky bus_err with cpu_done. When undefined, bus_err is 0.
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             arst,
  bus_cycle_ctrl_if.master bus,
  output bus_state_t       state_o
);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || TIMEOUT_CYC < 1 ||
      SETUP_CYC > (1 << CNT_W) || STROBE_CYC > (1 << CNT_W) ||
      HOLD_CYC > (1 << CNT_W) || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_bad_param
    $error("bus_cycle_ctrl: cycle parameters must be >= 1 and fit the counters");
  end

  // The timer is loaded with length-1 so that "expired" marks the last cycle.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  bus_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              mem_io_q;
  logic              done_q;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_expired;
  logic              accept;
  logic              strobe_exit;
  logic              hold_done;

  bus_phase_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .arst       (arst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

`ifdef BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  // tmo_cnt_q holds the 1-based index of the current strobe cycle.
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;
  logic             tmo_exit;
  logic             err_pend_q;
  logic             bus_err_q;

  assign tmo_hit = (state_q == ST_STROBE) && bus.WAIT && (tmo_cnt_q >= TIMEOUT_LIM);
`endif

  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    accept      = 1'b0;
    strobe_exit = 1'b0;
    hold_done   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_exit    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // DMA wins over the core; a request during the done pulse waits.
        if (bus.dma_req) begin
          state_d = ST_DMA;
        end else if (bus.cpu_req && !done_q) begin
          state_d  = ST_SETUP;
          accept   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_expired && !bus.WAIT) begin
          state_d     = ST_HOLD;
          strobe_exit = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = HOLD_LD;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d  = ST_HOLD;
          tmo_exit = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
`endif
      end
      ST_HOLD: begin
        if (tmr_expired) begin
          state_d   = ST_IDLE;
          hold_done = 1'b1;
        end
      end
      ST_DMA: begin
        if (!bus.dma_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      mem_io_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hold_done;
      if (accept) begin
        addr_q   <= bus.cpu_addr;
        wdata_q  <= bus.cpu_wdata;
        we_q     <= bus.cpu_we;
        mem_io_q <= bus.cpu_mem_io;
      end
      // Read data is taken only on the edge that ends the strobe.
      if (strobe_exit && !we_q) begin
        rdata_q <= bus.data_in;
      end
`ifdef BUS_TIMEOUT_EN
      if (tmo_exit) begin
        rdata_q <= '1;
      end
`endif
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (arst) begin
      tmo_cnt_q  <= '0;
      err_pend_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (state_q == ST_SETUP && tmr_expired) begin
        tmo_cnt_q <= CNT_W'(1);
      end else if (state_q == ST_STROBE && tmo_cnt_q != '1) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
      // The error shows up together with cpu_done and stays until the next
      // accepted request.
      if (accept) begin
        err_pend_q <= 1'b0;
        bus_err_q  <= 1'b0;
      end else begin
        if (tmo_exit) begin
          err_pend_q <= 1'b1;
        end
        if (hold_done && err_pend_q) begin
          bus_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.bus_err = bus_err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

  assign bus.addr      = addr_q;
  assign bus.mem_io    = mem_io_q;
  assign bus.data_out  = wdata_q;
  assign bus.data_oe   = we_q && (state_q == ST_SETUP || state_q == ST_STROBE ||
                                  state_q == ST_HOLD);
  assign bus.rd        = (state_q == ST_STROBE) && !we_q;
  assign bus.wr        = (state_q == ST_STROBE) && we_q;
  assign bus.dma_ack   = (state_q == ST_DMA);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cpu_done  = done_q;
  assign bus.cpu_rdata = rdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: self-checking bench for bus_cycle_ctrl (default timing,
// TIMEOUT_CYC overridden to 8 for builds with BUS_TIMEOUT_EN).
module tb_bus_cycle_ctrl;
  import bus_ctrl_pkg::*;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;
  localparam int TMO = 8;

  typedef struct {
    logic        we;
    logic        mio;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          w;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          exp_oe;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic       clk;
  logic       arst;
  bus_state_t dbg_state;
  int         n_vec;
  int         n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] model_rdata;

  bus_cycle_ctrl_if #(.ADDR_W(22), .DATA_W(8)) bif ();

  bus_cycle_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk     (clk),
    .arst    (arst),
    .bus     (bif),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: cycle shape follows from the phase lengths and the number of
  // extra WAIT cycles; read data is the value presented on the last strobe.
  function automatic vec_t model(input vec_t v, input logic [7:0] prev);
    vec_t r;
    int   strobe;
    r           = v;
    strobe      = T + v.w;
    r.exp_lat   = S + strobe + H;
    r.exp_rd    = v.we ? 0 : strobe;
    r.exp_wr    = v.we ? strobe : 0;
    r.exp_oe    = v.we ? r.exp_lat : 0;
    r.exp_rdata = v.we ? prev : v.din;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bif.cpu_req    = 1'b0;
    bif.cpu_we     = 1'b0;
    bif.cpu_mem_io = 1'b0;
    bif.cpu_addr   = '0;
    bif.cpu_wdata  = '0;
    bif.dma_req    = 1'b0;
    bif.WAIT       = 1'b0;
    bif.data_in    = '0;
  endtask

  task automatic set_req(input logic we, input logic mio, input logic [21:0] a,
                         input logic [7:0] wd);
    bif.cpu_req    = 1'b1;
    bif.cpu_we     = we;
    bif.cpu_mem_io = mio;
    bif.cpu_addr   = a;
    bif.cpu_wdata  = wd;
  endtask

  // Counts negedges until cpu_done is seen (bounded).
  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.cpu_done && n < limit);
    check("wait_done_seen", 32'(bif.cpu_done), 32'd1);
  endtask

  // Runs one CPU cycle from idle. WAIT is held so the strobe lasts T+w
  // cycles; data_in carries the real value only in the final strobe cycle.
  task automatic do_cycle(input vec_t v, input string tag);
    int         n, k, rd_n, wr_n, oe_n, addr_bad;
    bit         got_done;
    logic [7:0] exp_rd;
    n = 0; k = 0; rd_n = 0; wr_n = 0; oe_n = 0; addr_bad = 0; got_done = 0;
    exp_rd = exp_q.pop_front();
    set_req(v.we, v.mio, v.addr, v.wdata);
    bif.WAIT    = 1'b0;
    bif.data_in = ~v.din;
    while (!got_done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) bif.cpu_req = 1'b0;
      if (bif.cpu_done) begin
        got_done = 1;
      end else begin
        if (bif.rd) rd_n++;
        if (bif.wr) wr_n++;
        if (bif.data_oe) oe_n++;
        if (bif.busy && (bif.addr !== v.addr || bif.mem_io !== v.mio)) addr_bad++;
        if (bif.rd || bif.wr) begin
          k++;
          bif.WAIT    = (k < T + v.w);
          bif.data_in = (k == T + v.w) ? v.din : ~v.din;
        end else begin
          bif.WAIT    = 1'($urandom_range(0, 1));
          bif.data_in = ~v.din;
        end
      end
    end
    bif.WAIT = 1'b0;
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_latency"}, 32'(n - 1), 32'(v.exp_lat));
    check({tag, "_rd_cycles"}, 32'(rd_n), 32'(v.exp_rd));
    check({tag, "_wr_cycles"}, 32'(wr_n), 32'(v.exp_wr));
    check({tag, "_oe_cycles"}, 32'(oe_n), 32'(v.exp_oe));
    check({tag, "_addr_space_stable"}, 32'(addr_bad), 32'd0);
    check({tag, "_rdata"}, 32'(bif.cpu_rdata), 32'(exp_rd));
    check({tag, "_bus_err"}, 32'(bif.bus_err), 32'd0);
    if (v.we) check({tag, "_data_out"}, 32'(bif.data_out), 32'(v.wdata));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bif.cpu_done), 32'd0);
    check({tag, "_idle_after"}, 32'(bif.busy), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[5];

  initial begin
    int   n;
    int   dones;
    vec_t v;
    n_vec = 0;
    n_fail = 0;
    drive_idle();
    arst = 1'b1;

    tbl[0] = '{1'b0, 1'b1, 22'h12345,  8'h00, 8'hA5, 0, 4, 2, 0, 0, 8'hA5};
    tbl[1] = '{1'b1, 1'b0, 22'h00080,  8'h3C, 8'h00, 0, 4, 0, 2, 4, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 22'h3FFFFF, 8'h00, 8'h5A, 3, 7, 5, 0, 0, 8'h5A};
    tbl[3] = '{1'b1, 1'b1, 22'h000000, 8'hFF, 8'h99, 1, 5, 0, 3, 5, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 22'h2AAAAA, 8'h11, 8'h00, 0, 4, 2, 0, 0, 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_rd_wr_oe", 32'({bif.rd, bif.wr, bif.data_oe}), 32'd0);
    check("rst_addr", 32'(bif.addr), 32'd0);
    check("rst_data_out", 32'(bif.data_out), 32'd0);
    check("rst_rdata", 32'(bif.cpu_rdata), 32'd0);
    check("rst_misc", 32'({bif.mem_io, bif.dma_ack, bif.cpu_done, bif.bus_err}), 32'd0);
    arst = 1'b0;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(tbl[i].exp_rdata);
      do_cycle(tbl[i], $sformatf("tbl%0d", i));
    end

    // Randomized cycles against the reference model
    model_rdata = 8'h00;
    for (int i = 0; i < 24; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.mio   = 1'($urandom_range(0, 1));
      v.addr  = 22'($urandom);
      v.wdata = 8'($urandom);
      v.din   = 8'($urandom);
      v.w     = $urandom_range(0, 4);
      v = model(v, model_rdata);
      model_rdata = v.exp_rdata;
      exp_q.push_back(v.exp_rdata);
      do_cycle(v, $sformatf("rnd%0d", i));
    end

    // Request held through the done pulse is ignored for that one cycle
    set_req(1'b0, 1'b1, 22'h0ABCDE, 8'h00);
    bif.data_in = 8'h77;
    wait_done(20, n);
    check("hold_req_latency", 32'(n - 1), 32'(S + T + H));
    @(negedge clk);
    check("hold_req_done_width", 32'(bif.cpu_done), 32'd0);
    check("hold_req_ignored", 32'(bif.busy), 32'd0);
    @(negedge clk);
    check("hold_req_accepted", 32'(bif.busy), 32'd1);
    bif.cpu_req = 1'b0;
    wait_done(20, n);
    check("hold_req_rdata", 32'(bif.cpu_rdata), 32'h77);
    @(negedge clk);

    // DMA request mid-cycle waits for the cycle to finish
    set_req(1'b0, 1'b1, 22'h155555, 8'h00);
    bif.data_in = 8'hC3;
    @(negedge clk);
    bif.cpu_req = 1'b0;
    @(negedge clk);
    check("dma_strobe_rd", 32'(bif.rd), 32'd1);
    bif.dma_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("dma_no_truncate", 32'({bif.busy, bif.dma_ack}), 32'b10);
    @(negedge clk);
    check("dma_cpu_done", 32'(bif.cpu_done), 32'd1);
    check("dma_cpu_rdata", 32'(bif.cpu_rdata), 32'hC3);
    set_req(1'b1, 1'b0, 22'h001234, 8'h5E);
    @(negedge clk);
    check("dma_ack_rise", 32'(bif.dma_ack), 32'd1);
    check("dma_pins_quiet", 32'({bif.data_oe, bif.rd, bif.wr, bif.cpu_done}), 32'd0);
    check("dma_addr_held", 32'(bif.addr), 32'h155555);
    check("dma_mem_io_held", 32'(bif.mem_io), 32'd1);
    repeat (3) @(negedge clk);
    check("dma_ack_hold", 32'(bif.dma_ack), 32'd1);
    bif.dma_req = 1'b0;
    @(negedge clk);
    check("dma_ack_fall", 32'({bif.dma_ack, bif.busy}), 32'd0);
    @(negedge clk);
    check("dma_queued_req_start", 32'({bif.busy, bif.data_oe}), 32'b11);
    check("dma_queued_addr", 32'(bif.addr), 32'h001234);
    bif.cpu_req = 1'b0;
    wait_done(20, n);
    check("dma_queued_data_out", 32'(bif.data_out), 32'h5E);
    @(negedge clk);

    // Reset during the strobe aborts the cycle with no done pulse
    set_req(1'b0, 1'b1, 22'h3F0F0F, 8'h00);
    @(negedge clk);
    bif.cpu_req = 1'b0;
    @(negedge clk);
    check("arst_pre_rd", 32'(bif.rd), 32'd1);
    arst = 1'b1;
    @(negedge clk);
    check("arst_strobes", 32'({bif.rd, bif.wr, bif.data_oe, bif.busy}), 32'd0);
    check("arst_addr", 32'(bif.addr), 32'd0);
    check("arst_rdata", 32'(bif.cpu_rdata), 32'd0);
    check("arst_mem_io_done", 32'({bif.mem_io, bif.cpu_done}), 32'd0);
    arst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bif.cpu_done) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);

`ifdef BUS_TIMEOUT_EN
    // WAIT stuck high: forced end after TMO strobe cycles
    set_req(1'b0, 1'b1, 22'h000777, 8'h00);
    bif.WAIT    = 1'b1;
    bif.data_in = 8'h11;
    wait_done(40, n);
    check("tmo_latency", 32'(n - 1), 32'(S + TMO + H));
    check("tmo_bus_err", 32'(bif.bus_err), 32'd1);
    check("tmo_rdata", 32'(bif.cpu_rdata), 32'hFF);
    bif.cpu_req = 1'b0;
    bif.WAIT    = 1'b0;
    @(negedge clk);
    check("tmo_err_sticky", 32'(bif.bus_err), 32'd1);
    set_req(1'b0, 1'b1, 22'h000778, 8'h00);
    bif.data_in = 8'h22;
    @(negedge clk);
    check("tmo_err_cleared", 32'(bif.bus_err), 32'd0);
    bif.cpu_req = 1'b0;
    wait_done(20, n);
    check("tmo_next_rdata", 32'(bif.cpu_rdata), 32'h22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
